// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared types, defaults and the round-robin pick function for rr_onehot_arbiter.
// Optional feature macro used by the slice: RR_ARB_TIMEOUT_EN.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned RR_NUM_REQ_DEF = 16;
    localparam int unsigned RR_TIMEOUT_DEF = 255;
    // Upper bound on requesters supported by rr_pick.
    localparam int unsigned RR_MAX_REQ     = 64;
    localparam int unsigned RR_MAX_W       = 6;

    // First set bit of req scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
    function automatic logic [RR_MAX_W-1:0] rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                                    input int unsigned ptr,
                                                    input int unsigned n);
        logic [RR_MAX_W-1:0] win;
        logic                found;
        int unsigned         k;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            if (i < n && !found) begin
                k = ptr + i;
                if (k >= n) k = k - n;
                if (req[k[RR_MAX_W-1:0]]) begin
                    win   = k[RR_MAX_W-1:0];
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between requester agents (master) and the arbiter (slave).
// Optional feature macro affecting timeout_o: RR_ARB_TIMEOUT_EN.
interface rr_onehot_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = RR_NUM_REQ_DEF,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req_i;
    logic               done_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic [IDX_W-1:0]   gnt_idx_o;
    logic               gnt_valid_o;
    logic               timeout_o;

    modport master (
        output req_i, done_i,
        input  gnt_o, gnt_idx_o, gnt_valid_o, timeout_o
    );

    modport slave (
        input  req_i, done_i,
        output gnt_o, gnt_idx_o, gnt_valid_o, timeout_o
    );
endinterface

// File: rtl/rr_onehot_arbiter_bin_to_onehot.sv
// Combinational binary-to-one-hot decoder driving the resource select lines.
// Output is all zero while en is low.
module bin_to_onehot
    import rr_arb_pkg::*;
#(
    parameter int unsigned BIN_W     = 4,
    parameter int unsigned ONE_HOT_W = 16
) (
    input  logic [BIN_W-1:0]     bin,
    input  logic                 en,
    output logic [ONE_HOT_W-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < ONE_HOT_W; i++) begin
            if (en && bin == BIN_W'(i)) onehot[i] = 1'b1;
        end
    end
endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter holding each grant until done; one-hot select via bin_to_onehot.
// Define RR_ARB_TIMEOUT_EN to force release after TIMEOUT_CYC grant cycles.
module rr_onehot_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = RR_NUM_REQ_DEF,
    parameter int unsigned IDX_W       = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT_CYC = RR_TIMEOUT_DEF
) (
    input logic          clk,
    input logic          reset,
    rr_onehot_arbiter_if.slave bus
);
    if (NUM_REQ < 2 || NUM_REQ > RR_MAX_REQ || TIMEOUT_CYC < 1) begin : g_param_check
        $error("rr_onehot_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             gnt_valid;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             expire;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        // cnt_q counts completed GRANT cycles, so expiry fires in cycle TIMEOUT_CYC.
        expire    = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req_i) begin
                    state_d = GRANT;
                    idx_d   = IDX_W'(rr_pick(RR_MAX_REQ'(bus.req_i), 32'(ptr_q), NUM_REQ));
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
`ifdef RR_ARB_TIMEOUT_EN
                if (bus.done_i || expire) begin
                    timeout_d = !bus.done_i;
`else
                if (bus.done_i) begin
`endif
                    state_d = IDLE;
                    idx_d   = '0;
                    ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                end
`ifdef RR_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt_valid       = (state_q == GRANT);
        bus.gnt_valid_o = gnt_valid;
        bus.gnt_idx_o   = idx_q;
`ifdef RR_ARB_TIMEOUT_EN
        bus.timeout_o   = timeout_q;
`else
        bus.timeout_o   = 1'b0;
`endif
    end

    bin_to_onehot #(
        .BIN_W     (IDX_W),
        .ONE_HOT_W (NUM_REQ)
    ) u_dec (
        .bin    (idx_q),
        .en     (gnt_valid),
        .onehot (bus.gnt_o)
    );
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter (NUM_REQ=4, TIMEOUT_CYC=8).
// Honours RR_ARB_TIMEOUT_EN the same way as the RTL.
module tb_rr_onehot_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    int   m_owner;
    int   m_ptr;
    int   m_held;
    bit   m_to;

    rr_onehot_arbiter_if #(.NUM_REQ(N)) bus();

    rr_onehot_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_release();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
    endtask

    // Reference behaviour: one call per rising edge using the inputs sampled there.
    task automatic model_step();
        m_to = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            if (bus.req_i != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.req_i[(m_ptr + i) % N]) begin
                        m_owner = (m_ptr + i) % N;
                        break;
                    end
                end
                m_held = 1;
            end
        end else if (bus.done_i) begin
            model_release();
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            if (m_held == TO) begin
                m_to = 1'b1;
                model_release();
            end else begin
                m_held++;
            end
`endif
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_gnt;
        @(posedge clk);
        model_step();
        #1;
        exp_gnt = (m_owner < 0) ? '0 : N'(1 << m_owner);
        check("gnt",     32'(bus.gnt_o),       32'(exp_gnt));
        check("gnt_idx", 32'(bus.gnt_idx_o),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("valid",   32'(bus.gnt_valid_o), 32'(m_owner >= 0));
        check("timeout", 32'(bus.timeout_o),   32'(m_to));
        check("onehot0", 32'($countones(bus.gnt_o) <= 1), 32'd1);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic d);
        bus.req_i  = r;
        bus.done_i = d;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
        reset   = 1'b1;
        drive(4'b1111, 1'b0);

        // Reset held two cycles with all requesters active
        tick();
        tick();
        check("rst_gnt",   32'(bus.gnt_o), 32'd0);
        check("rst_valid", 32'(bus.gnt_valid_o), 32'd0);
        reset = 1'b0;
        tick();
        check("first_gnt", 32'(bus.gnt_o), 32'b0001);

        // Rotation 0,1,2,3,0 with one bubble between grants
        for (int k = 1; k <= 4; k++) begin
            drive(4'b1111, 1'b1);
            tick();
            check("bubble", 32'(bus.gnt_valid_o), 32'd0);
            drive(4'b1111, 1'b0);
            tick();
            check("rot_idx", 32'(bus.gnt_idx_o), 32'(k % N));
        end

        // Skip and wrap: grant 2, then ptr=3 with req 0101 picks 0, then 2
        drive(4'b0100, 1'b1); tick();
        drive(4'b0100, 1'b0); tick();
        check("grant2", 32'(bus.gnt_o), 32'b0100);
        drive(4'b0101, 1'b1); tick();
        drive(4'b0101, 1'b0); tick();
        check("wrap0", 32'(bus.gnt_o), 32'b0001);
        drive(4'b0101, 1'b1); tick();
        drive(4'b0101, 1'b0); tick();
        check("next2", 32'(bus.gnt_o), 32'b0100);

        // Hold: grant 1 with its request dropped and no done
        drive(4'b0010, 1'b1); tick();
        drive(4'b0010, 1'b0); tick();
        check("grant1", 32'(bus.gnt_o), 32'b0010);
`ifndef RR_ARB_TIMEOUT_EN
        drive(4'b0000, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("hold", 32'(bus.gnt_o), 32'b0010);
        end
`endif
        drive(4'b0000, 1'b1); tick();
        check("hold_rel", 32'(bus.gnt_o), 32'd0);
        drive(4'b1111, 1'b0); tick();
        check("ptr2", 32'(bus.gnt_idx_o), 32'd2);

        // Mid-grant reset on owner 3, next scan from 0
        drive(4'b1000, 1'b1); tick();
        drive(4'b1000, 1'b0); tick();
        check("grant3", 32'(bus.gnt_o), 32'b1000);
        reset = 1'b1; tick();
        check("mid_rst", 32'(bus.gnt_valid_o), 32'd0);
        reset = 1'b0;
        drive(4'b1111, 1'b0); tick();
        check("post_rst", 32'(bus.gnt_o), 32'b0001);

`ifdef RR_ARB_TIMEOUT_EN
        // Forced release after TO grant cycles, then next grant to 3
        drive(4'b0100, 1'b1); tick();
        drive(4'b0100, 1'b0); tick();
        check("to_grant2", 32'(bus.gnt_o), 32'b0100);
        drive(4'b1100, 1'b0);
        for (int c = 1; c < TO; c++) begin
            tick();
            check("to_hold", 32'(bus.timeout_o), 32'd0);
        end
        tick();
        check("to_pulse", 32'(bus.timeout_o), 32'd1);
        tick();
        check("to_next3", 32'(bus.gnt_o), 32'b1000);
        check("to_clear", 32'(bus.timeout_o), 32'd0);
`endif

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive(N'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
            tick();
            if (bus.gnt_valid_o)
                check("inv_idx", 32'(bus.gnt_o), 32'(1 << bus.gnt_idx_o));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
